dekoder_segmentow: RTL and testbench
====================================

DEKODER_SEGMENTOW -- requirements
Module: dekoder_segmentow

Interface
REQ-001 SHALL have parameter STAB_CYCLES, default 4, range 1..15: consecutive identical samples required before a digit is accepted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port segmenty  input  8  active-low segment bus; bit7 = dp, bits6..0 = g..a.
REQ-005 SHALL have port anody  input  4  active-low digit select of a scanned 4-digit display; index 0 = least significant digit.
REQ-006 SHALL have port cyfry  output  16  decoded BCD frame; digit i in bits 4i+3..4i.
REQ-007 SHALL have port kropki  output  4  captured decimal points, 1 = dp lit.
REQ-008 SHALL have port wynik_valid  output  1  frame available on cyfry/kropki.
REQ-009 SHALL have port wynik_ready  input  1  consumer accepts frame.
REQ-010 SHALL have port blad  output  1  sticky flag: unknown pattern decoded in the last delivered frame.
REQ-011 SHALL have port przepelnienie  output  1  sticky flag: a completed frame was dropped.

Function
REQ-012 SHALL decode bits6..0: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9 (hex); any other value -> digit 4'hF and marks the frame erroneous.
REQ-013 SHALL treat anody as valid only when exactly one bit is 0; any other value (1111, multiple zeros) is blanking.
REQ-014 SHALL implement FSM CZEKAJ / LICZ / ZAPISANY; reset state CZEKAJ.
REQ-015 CZEKAJ: on valid anody, register anody and segmenty, counter = 1, go LICZ.
REQ-016 LICZ: if anody and segmenty equal registered values, increment; when counter reaches STAB_CYCLES, write decoded digit into slot, set slot bit in seen mask, go ZAPISANY; on any mismatch or blanking, go CZEKAJ, nothing written.
REQ-017 ZAPISANY: stay while anody unchanged; on any change of anody, go CZEKAJ (the next anode sampled on the following cycle).
REQ-018 A digit SHALL be accepted at the earliest STAB_CYCLES cycles after the first sample; rewriting an already-seen slot before frame completion SHALL overwrite it.
REQ-019 When the seen mask becomes 1111, frame completion SHALL occur in the same cycle as the last write: mask cleared, frame error flag evaluated including the last digit.
REQ-020 On completion with wynik_valid=0 or (wynik_valid=1 and wynik_ready=1): cyfry/kropki/blad updated next cycle, wynik_valid=1.
REQ-021 On completion with wynik_valid=1 and wynik_ready=0: frame dropped, outputs unchanged, przepelnienie set to 1.
REQ-022 wynik_valid SHALL clear on a cycle with wynik_ready=1 unless a frame completes in that cycle; cyfry/kropki/blad SHALL be stable while wynik_valid=1.
REQ-023 blad SHALL reflect the last delivered frame only; przepelnienie SHALL remain 1 until reset.

Reset
REQ-024 On rst_n=0, asynchronously: FSM=CZEKAJ, counter=0, seen mask=0000, cyfry=16'h0000, kropki=4'b0000, wynik_valid=0, blad=0, przepelnienie=0.
REQ-025 Reset mid-frame SHALL discard all partially collected digits; first frame after release requires all four digits anew.

Configuration
REQ-026 With macro KROPKA_CAPTURE_EN defined: slot's dp (inverted segmenty bit7) captured with the digit and delivered on kropki; bit7 participates in the stability compare.
REQ-027 Without KROPKA_CAPTURE_EN: kropki tied to 4'b0000, bit7 ignored for decode and stability.

Verification
REQ-028 Reset, then scan 1,2,3,4 on anody 1110,1101,1011,0111, each held 6 cycles, STAB_CYCLES=4 -> single wynik_valid with cyfry=16'h4321, blad=0.
REQ-029 Segment 8'hFF on one slot, others valid -> cyfry holds F in that nibble, blad=1; next clean frame -> blad=0.
REQ-030 Slot held 3 cycles with STAB_CYCLES=4, then anode change -> no write, no wynik_valid after one scan.
REQ-031 wynik_ready=0 while a second full frame completes -> first frame unchanged, przepelnienie=1; then wynik_ready=1 -> wynik_valid=0 next cycle.
REQ-032 rst_n pulsed low after three digits collected -> all outputs 0 immediately; next frame requires four digits.
REQ-033 KROPKA_CAPTURE_EN defined, digit 5 sent as 8'h12 on slot 2 -> kropki=4'b0100; macro undefined -> kropki=4'b0000, digit still 5.

Source files
------------

// File: rtl/dekoder_segmentow_if.sv
// Bus between a scanned 4-digit 7-segment display tap and the frame consumer.
// master: display side plus consumer (drives segments/anodes/ready).
// slave:  the decoder (drives the decoded frame and status flags).
interface dekoder_segmentow_if;
  logic [7:0]  segmenty;       // active-low, bit7 = dp, bits6..0 = g..a
  logic [3:0]  anody;          // active-low digit select, bit0 = least significant
  logic        wynik_ready;
  logic [15:0] cyfry;
  logic [3:0]  kropki;
  logic        wynik_valid;
  logic        blad;
  logic        przepelnienie;

  modport master (
    output segmenty, anody, wynik_ready,
    input  cyfry, kropki, wynik_valid, blad, przepelnienie
  );

  modport slave (
    input  segmenty, anody, wynik_ready,
    output cyfry, kropki, wynik_valid, blad, przepelnienie
  );
endinterface

// File: rtl/dekoder_segmentow.sv
// Decoder that snoops a multiplexed 4-digit 7-segment display and rebuilds the
// shown number as a BCD frame. A digit is accepted after STAB_CYCLES identical
// samples; a frame is delivered once all four slots have been seen.
// Optional feature: define KROPKA_CAPTURE_EN to capture decimal points on kropki.
module dekoder_segmentow #(
  parameter int unsigned STAB_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  dekoder_segmentow_if.slave bus
);

`ifdef KROPKA_CAPTURE_EN
  localparam int unsigned CmpW = 8;   // dp takes part in the stability compare
`else
  localparam int unsigned CmpW = 7;
`endif

  localparam logic [3:0] StabCnt = 4'(STAB_CYCLES);

  typedef enum logic [1:0] {
    StCzekaj   = 2'd0,
    StLicz     = 2'd1,
    StZapisany = 2'd2
  } stan_e;

  stan_e            r_state;
  logic [3:0]       r_cnt;
  logic [3:0]       r_mask;
  logic [3:0]       r_anody;
  logic [CmpW-1:0]  r_seg;
  logic [15:0]      r_frame;
  logic [3:0]       r_bad;

  logic [15:0]      r_cyfry;
  logic             r_valid;
  logic             r_blad;
  logic             r_przep;

  logic             w_anode_ok;
  logic [3:0]       w_zeros;
  logic [1:0]       w_slot;
  logic [CmpW-1:0]  w_seg_cmp;
  logic             w_match;
  logic [3:0]       w_digit;
  logic             w_write;
  logic [3:0]       w_mask_nxt;
  logic             w_done;
  logic [15:0]      w_frame_nxt;
  logic [3:0]       w_bad_nxt;

  function automatic logic [3:0] dekoduj(input logic [6:0] seg);
    case (seg)
      7'h40:   return 4'd0;
      7'h79:   return 4'd1;
      7'h24:   return 4'd2;
      7'h30:   return 4'd3;
      7'h19:   return 4'd4;
      7'h12:   return 4'd5;
      7'h02:   return 4'd6;
      7'h78:   return 4'd7;
      7'h00:   return 4'd8;
      7'h10:   return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  assign w_seg_cmp = bus.segmenty[CmpW-1:0];
  assign w_zeros   = ~bus.anody;
  // Exactly one anode low: non-zero and a power of two.
  assign w_anode_ok = (w_zeros != 4'd0) && ((w_zeros & (w_zeros - 4'd1)) == 4'd0);
  assign w_match    = (bus.anody == r_anody) && (w_seg_cmp == r_seg);
  assign w_digit    = dekoduj(bus.segmenty[6:0]);

  // Slot index of the active anode; only meaningful when w_anode_ok.
  always_comb begin
    w_slot = 2'd0;
    case (bus.anody)
      4'b1110: w_slot = 2'd0;
      4'b1101: w_slot = 2'd1;
      4'b1011: w_slot = 2'd2;
      4'b0111: w_slot = 2'd3;
      default: w_slot = 2'd0;
    endcase
  end

  // Accept the digit on the sample that makes the run STAB_CYCLES long.
  always_comb begin
    w_write = 1'b0;
    if (r_state == StCzekaj && w_anode_ok && StabCnt == 4'd1) begin
      w_write = 1'b1;
    end else if (r_state == StLicz && w_match && (r_cnt + 4'd1) == StabCnt) begin
      w_write = 1'b1;
    end
  end

  // Collection buffer as it would look after this cycle's write.
  always_comb begin
    w_frame_nxt = r_frame;
    w_bad_nxt   = r_bad;
    w_mask_nxt  = r_mask;
    if (w_write) begin
      w_frame_nxt[{w_slot, 2'b00} +: 4] = w_digit;
      w_bad_nxt[w_slot]                 = (w_digit == 4'hF);
      w_mask_nxt[w_slot]                = 1'b1;
    end
  end

  assign w_done = w_write && (w_mask_nxt == 4'hF);

  // Sampling FSM and digit collection buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StCzekaj;
      r_cnt   <= 4'd0;
      r_mask  <= 4'd0;
      r_anody <= 4'hF;
      r_seg   <= '0;
      r_frame <= 16'h0000;
      r_bad   <= 4'd0;
    end else begin
      unique case (r_state)
        StCzekaj: begin
          if (w_anode_ok) begin
            r_anody <= bus.anody;
            r_seg   <= w_seg_cmp;
            r_cnt   <= 4'd1;
            r_state <= (StabCnt == 4'd1) ? StZapisany : StLicz;
          end
        end
        StLicz: begin
          if (w_match) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_write) r_state <= StZapisany;
          end else begin
            r_state <= StCzekaj;
          end
        end
        StZapisany: begin
          // The new anode is not sampled now; CZEKAJ picks it up next cycle.
          if (bus.anody != r_anody) r_state <= StCzekaj;
        end
        default: r_state <= StCzekaj;
      endcase
      if (w_write) begin
        r_frame <= w_frame_nxt;
        r_bad   <= w_bad_nxt;
        r_mask  <= w_done ? 4'd0 : w_mask_nxt;
      end
    end
  end

  // Output stage: deliver completed frames, drop them while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyfry <= 16'h0000;
      r_valid <= 1'b0;
      r_blad  <= 1'b0;
      r_przep <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || bus.wynik_ready) begin
        r_cyfry <= w_frame_nxt;
        r_blad  <= |w_bad_nxt;
        r_valid <= 1'b1;
      end else begin
        r_przep <= 1'b1;
      end
    end else if (bus.wynik_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef KROPKA_CAPTURE_EN
  logic [3:0] r_dp;
  logic [3:0] r_kropki;
  logic [3:0] w_dp_nxt;

  // Decimal point of the slot being written, in the same view as the buffer.
  always_comb begin
    w_dp_nxt = r_dp;
    if (w_write) w_dp_nxt[w_slot] = ~bus.segmenty[7];
  end

  // Collected dots and their delivered copy follow the digit buffer/outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp     <= 4'd0;
      r_kropki <= 4'd0;
    end else begin
      if (w_write) r_dp <= w_dp_nxt;
      if (w_done && (!r_valid || bus.wynik_ready)) r_kropki <= w_dp_nxt;
    end
  end

  assign bus.kropki = r_kropki;
`else
  logic w_unused_dp;
  assign w_unused_dp = bus.segmenty[7];
  assign bus.kropki  = 4'b0000;
`endif

  assign bus.cyfry         = r_cyfry;
  assign bus.wynik_valid   = r_valid;
  assign bus.blad          = r_blad;
  assign bus.przepelnienie = r_przep;

endmodule

// File: tb/tb_dekoder_segmentow.sv
// Bench for dekoder_segmentow: directed scans followed by random scans, checked
// against a slot/frame level model of the display decoder.
module tb_dekoder_segmentow;
  localparam int STAB = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   rises;
  logic prev_valid;

  dekoder_segmentow_if bus();

  dekoder_segmentow #(
    .STAB_CYCLES(STAB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges of wynik_valid.
  always @(posedge clk) begin
    prev_valid <= bus.wynik_valid;
    if (bus.wynik_valid && !prev_valid) rises <= rises + 1;
  end

  // Segment patterns (bits6..0) of digits 0..9.
  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state.
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dp;
  logic [3:0]  m_seen;
  logic [15:0] exp_cyfry;
  logic [3:0]  exp_kropki;
  logic        exp_valid;
  logic        exp_blad;
  logic        exp_ovf;

  function automatic logic [3:0] ref_digit(input logic [7:0] seg);
    for (int d = 0; d < 10; d++) begin
      if (seg[6:0] == pat[d]) return 4'(d);
    end
    return 4'hF;
  endfunction

  function automatic logic [7:0] seg_of(input int d, input logic dp);
    return {~dp, pat[d]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cyfry"}, 32'(bus.cyfry), 32'(exp_cyfry));
    chk({tag, ".kropki"}, 32'(bus.kropki), 32'(exp_kropki));
    chk({tag, ".valid"}, 32'(bus.wynik_valid), 32'(exp_valid));
    chk({tag, ".blad"}, 32'(bus.blad), 32'(exp_blad));
    chk({tag, ".przep"}, 32'(bus.przepelnienie), 32'(exp_ovf));
  endtask

  task automatic model_reset();
    m_seen     = 4'd0;
    m_dp       = 4'd0;
    exp_cyfry  = 16'h0;
    exp_kropki = 4'd0;
    exp_valid  = 1'b0;
    exp_blad   = 1'b0;
    exp_ovf    = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
  endtask

  task automatic model_accept(input int slot, input logic [7:0] seg, input logic rdy);
    m_dig[slot]  = ref_digit(seg);
    m_dp[slot]   = ~seg[7];
    m_seen[slot] = 1'b1;
    if (m_seen == 4'hF) begin
      m_seen = 4'd0;
      if (!exp_valid || rdy) begin
        exp_cyfry = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        exp_blad  = 1'b0;
        for (int i = 0; i < 4; i++) if (m_dig[i] == 4'hF) exp_blad = 1'b1;
`ifdef KROPKA_CAPTURE_EN
        exp_kropki = m_dp;
`else
        exp_kropki = 4'b0000;
`endif
        exp_valid = 1'b1;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  // Show one digit for cyc cycles, then blank the display for one cycle.
  task automatic scan(input int slot, input logic [7:0] seg, input int cyc, input logic rdy);
    bus.wynik_ready = rdy;
    bus.anody       = ~(4'b0001 << slot);
    bus.segmenty    = seg;
    tick(cyc);
    bus.anody    = 4'hF;
    bus.segmenty = 8'hFF;
    tick(1);
    bus.wynik_ready = 1'b0;
    if (cyc >= STAB + 2) model_accept(slot, seg, rdy);
    if (rdy) exp_valid = 1'b0;
  endtask

  task automatic consume();
    bus.wynik_ready = 1'b1;
    tick(1);
    bus.wynik_ready = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic frame(input int d0, input int d1, input int d2, input int d3);
    scan(0, seg_of(d0, 1'b0), 6, 1'b0);
    scan(1, seg_of(d1, 1'b0), 6, 1'b0);
    scan(2, seg_of(d2, 1'b0), 6, 1'b0);
    scan(3, seg_of(d3, 1'b0), 6, 1'b0);
  endtask

  initial begin
    int r0;
    int slot;
    int cyc;
    logic [7:0] seg;
    logic rdy;

    checks          = 0;
    failures        = 0;
    rises           = 0;
    prev_valid      = 1'b0;
    rst_n           = 1'b0;
    bus.anody       = 4'hF;
    bus.segmenty    = 8'hFF;
    bus.wynik_ready = 1'b0;
    model_reset();
    tick(2);
    check_all("reset");
    rst_n = 1'b1;
    tick(1);

    // Basic frame 4321: exactly one valid pulse.
    r0 = rises;
    frame(1, 2, 3, 4);
    chk("basic.cyfry_const", 32'(bus.cyfry), 32'h4321);
    chk("basic.rises", 32'(rises - r0), 32'd1);
    check_all("basic");
    consume();
    check_all("consume1");

    // Unknown pattern in slot 2, then a clean frame clears blad.
    scan(0, seg_of(7, 1'b0), 6, 1'b0);
    scan(1, seg_of(0, 1'b0), 6, 1'b0);
    scan(2, 8'hFF, 6, 1'b0);
    scan(3, seg_of(9, 1'b0), 6, 1'b0);
    chk("bad.cyfry_const", 32'(bus.cyfry), 32'h9F07);
    chk("bad.blad_const", 32'(bus.blad), 32'd1);
    check_all("bad");
    consume();
    frame(5, 6, 8, 0);
    chk("clean.blad_const", 32'(bus.blad), 32'd0);
    check_all("clean");
    consume();

    // Slot held one cycle too short is not written.
    r0 = rises;
    scan(0, seg_of(3, 1'b0), STAB - 1, 1'b0);
    scan(1, seg_of(3, 1'b0), 6, 1'b0);
    scan(2, seg_of(3, 1'b0), 6, 1'b0);
    scan(3, seg_of(3, 1'b0), 6, 1'b0);
    chk("short.rises", 32'(rises - r0), 32'd0);
    check_all("short");
    scan(0, seg_of(2, 1'b0), 6, 1'b0);
    check_all("short_done");

    // Stalled consumer: second frame dropped, first kept.
    frame(9, 9, 1, 1);
    chk("ovf.kept_const", 32'(bus.cyfry), 32'h3332);
    chk("ovf.flag_const", 32'(bus.przepelnienie), 32'd1);
    check_all("ovf");
    consume();
    check_all("ovf_consume");

    // Completion while valid=1 and ready=1 replaces the frame.
    frame(1, 1, 1, 1);
    scan(0, seg_of(6, 1'b0), 6, 1'b0);
    scan(1, seg_of(7, 1'b0), 6, 1'b0);
    scan(2, seg_of(8, 1'b0), 6, 1'b0);
    scan(3, seg_of(5, 1'b0), 6, 1'b1);
    check_all("readyhit");

    // Reset after three digits: everything cleared, four digits needed again.
    scan(0, seg_of(4, 1'b0), 6, 1'b0);
    scan(1, seg_of(4, 1'b0), 6, 1'b0);
    scan(2, seg_of(4, 1'b0), 6, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    scan(3, seg_of(4, 1'b0), 6, 1'b0);
    scan(0, seg_of(2, 1'b0), 6, 1'b0);
    scan(1, seg_of(2, 1'b0), 6, 1'b0);
    chk("postreset.novalid", 32'(bus.wynik_valid), 32'd0);
    scan(2, seg_of(2, 1'b0), 6, 1'b0);
    check_all("postreset");
    consume();

    // Decimal point on slot 2 with digit 5 (pattern 8'h12).
    scan(0, seg_of(1, 1'b0), 6, 1'b0);
    scan(1, seg_of(2, 1'b0), 6, 1'b0);
    scan(2, 8'h12, 6, 1'b0);
    scan(3, seg_of(3, 1'b0), 6, 1'b0);
    check_all("dot");
    consume();

    // Random scans.
    for (int n = 0; n < 60; n++) begin
      slot = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) seg = 8'($urandom);
      else seg = seg_of(int'($urandom_range(0, 9)), 1'($urandom));
      cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, STAB - 1)) : STAB + 2;
      rdy = ($urandom_range(0, 3) == 0);
      scan(slot, seg, cyc, rdy);
      check_all("rand");
      if ($urandom_range(0, 3) == 0) begin
        consume();
        check_all("rand_consume");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
